dplca_txop_table_eval: RTL and testbench
========================================

Name: dplca_txop_table_eval

Overview:
- Sits directly downstream of the DPLCA aging/claim-table machine (Clause 148.9).
- On each rising edge of dplca_txop_table_upd, it snapshots the 256-entry TXOP claim table and scans it one entry per clock.
- It publishes the claimed-TXOP count, the highest claimed ID, a recommended PLCA max ID, and the lowest free node ID.
- These results feed DPLCA node-ID acquisition and max-ID update logic.

Parameters:
- MAX_ID_HEADROOM, 1, spare TXOPs added above the highest claimed ID when computing dplca_max_id_calc.
- FREE_ID_MIN, 1, lowest ID eligible as a free ID (ID 0 is reserved for the coordinator).
- FREE_ID_MAX, 254, highest ID eligible as a free ID (ID 255 is the unassigned ID).

Ports:
- clk  input  1  block clock.
- reset  input  1  synchronous, active-high reset.
- dplca_txop_table_upd  input  1  table-updated notification from the aging machine (level).
- txop_claim_table_unpacked  input  512  claim table; entry i at bits [2i+1:2i]; 2'b01 = CLAIMED, any other value = unclaimed.
- eval_busy  output  1  high from SNAPSHOT through CALC.
- eval_done  output  1  one-cycle pulse when the result outputs update.
- claimed_cnt  output  9  number of CLAIMED entries, 0..256.
- highest_claimed_id  output  8  highest CLAIMED index.
- highest_claimed_valid  output  1  at least one entry is CLAIMED.
- dplca_max_id_calc  output  8  recommended max ID.
- free_id  output  8  lowest unclaimed ID in FREE_ID_MIN..FREE_ID_MAX.
- free_id_valid  output  1  a free ID exists.

Behaviour:
- Reset values:
  - All outputs are 0 except free_id = FREE_ID_MIN.
  - Edge-detect register = 0; pending = 0.
  - State = IDLE.
- States: IDLE, SNAPSHOT, SCAN, CALC, DONE.
  - IDLE: waits for a rising edge of upd (upd = 1 with the registered previous value = 0), then goes to SNAPSHOT.
  - SNAPSHOT: registers the full 512-bit table; clears the scan accumulators; idx = 0.
  - SCAN: examines entry idx each cycle.
    - If entry == 2'b01: claimed count +1; highest = idx.
    - If entry != 2'b01, idx is within FREE_ID_MIN..FREE_ID_MAX, and no free ID has been found yet: latch free = idx.
    - At idx = 255, go to CALC. idx is 8 bits and must not wrap into a second pass.
  - CALC: dplca_max_id_calc = highest + 1 + MAX_ID_HEADROOM, computed 10 bits wide and saturated to 255. If none claimed, the result is MAX_ID_HEADROOM.
  - DONE: outputs are registered on entry; eval_done = 1 for exactly one cycle. Next state is SNAPSHOT if pending, else IDLE; pending is cleared.
- Latency: counting the edge-detect cycle as cycle 0, SNAPSHOT is cycle 1, SCAN is cycles 2..257, CALC is cycle 258, and eval_done is high in cycle 259.
- Result outputs hold their values until the next DONE.
- A rising upd edge during SNAPSHOT, SCAN, CALC or DONE sets pending. Multiple such edges collapse to one. The scan in progress is never restarted.
- The table may change after SNAPSHOT; the scan uses only the snapshot.
- upd held high continuously does not retrigger.
- Reset mid-operation aborts the scan; all outputs return to reset values on the next edge.

Optional Feature:
- Macro: DPLCA_EVAL_STATS_EN.
- When defined, two output ports are added:
  - eval_cnt[15:0]: increments on each DONE; wraps.
  - overrun_cnt[7:0]: increments when an edge arrives while pending is already 1; saturates at 255.
  - Both reset to 0.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package / param include holds:
  - CLAIMED = 2'b01 and UNCLAIMED = 2'b00 (shared with the aging machine).
  - The state encodings (IDLE = 3'b000 .. DONE = 3'b100).
  - The table-depth constant 256.
- Natural sub-module: dplca_claim_scan_acc, which holds the per-entry accumulator (count, highest, first-free latch) with clear/enable inputs. The FSM stays in the top level.

Test Plan:
- Hold reset 3 cycles, then release → all outputs at reset values, eval_busy = 0, no eval_done.
- All-unclaimed table, upd 0→1 → eval_done at cycle 259; claimed_cnt = 0, highest_claimed_valid = 0, dplca_max_id_calc = 1, free_id = 1, free_id_valid = 1.
- IDs 0, 1, 3, 7 CLAIMED → claimed_cnt = 4, highest_claimed_id = 7, dplca_max_id_calc = 9, free_id = 2.
- IDs 0..255 all CLAIMED → claimed_cnt = 256, dplca_max_id_calc = 255 (saturated), free_id_valid = 0.
- Second upd edge at cycle 100 of a scan, with the table changed after SNAPSHOT → first eval_done reports the old snapshot; second eval_done reports the new table. With DPLCA_EVAL_STATS_EN, eval_cnt = 2.
- reset asserted at cycle 150 of a scan → outputs return to reset values; no eval_done; a fresh upd edge after release completes normally.

Source files
------------

// File: rtl/dplca_txop_table_eval_pkg.sv
// Shared constants for the DPLCA claim-table evaluator: entry encodings, table depth,
// FSM state encodings and the saturating max-ID helper.
package dplca_txop_table_eval_pkg;
  localparam logic [1:0] CLAIMED   = 2'b01;
  localparam logic [1:0] UNCLAIMED = 2'b00;
  localparam int         TBL_DEPTH = 256;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_SNAPSHOT = 3'b001,
    ST_SCAN     = 3'b010,
    ST_CALC     = 3'b011,
    ST_DONE     = 3'b100
  } state_t;

  // highest + 1 + headroom, evaluated 10 bits wide so 254/255 + 2 cannot wrap.
  function automatic logic [7:0] sat_max_id(input logic [7:0] hi, input logic hv,
                                            input logic [7:0] headroom);
    logic [9:0] s;
    s = {2'b00, hi} + 10'd1 + {2'b00, headroom};
    if (!hv) return headroom;
    return (s > 10'd255) ? 8'hff : s[7:0];
  endfunction
endpackage

// File: rtl/dplca_txop_table_eval_scan_acc.sv
// Per-entry scan accumulator: claimed count, highest claimed index and first free index.
// Cleared at snapshot time, advanced once per scanned entry.
module dplca_claim_scan_acc
  import dplca_txop_table_eval_pkg::*;
#(
  parameter int FREE_ID_MIN = 1,
  parameter int FREE_ID_MAX = 254
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_idx,
  input  logic [1:0] i_entry,
  output logic [8:0] o_cnt,
  output logic [7:0] o_highest,
  output logic       o_hvalid,
  output logic [7:0] o_free,
  output logic       o_fvalid
);
  logic w_in_rng;
  assign w_in_rng = (i_idx >= 8'(FREE_ID_MIN)) && (i_idx <= 8'(FREE_ID_MAX));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      o_cnt     <= '0;
      o_highest <= '0;
      o_hvalid  <= 1'b0;
      o_free    <= 8'(FREE_ID_MIN);
      o_fvalid  <= 1'b0;
    end else if (i_en) begin
      if (i_entry == CLAIMED) begin
        o_cnt     <= o_cnt + 9'd1;
        o_highest <= i_idx;
        o_hvalid  <= 1'b1;
      end else if (w_in_rng && !o_fvalid) begin
        o_free   <= i_idx;
        o_fvalid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/dplca_txop_table_eval.sv
// DPLCA TXOP claim-table evaluator: snapshots the table on an upd rising edge and scans it
// one entry per clock. Optional DPLCA_EVAL_STATS_EN adds eval_cnt / overrun_cnt ports.
module dplca_txop_table_eval
  import dplca_txop_table_eval_pkg::*;
#(
  parameter int MAX_ID_HEADROOM = 1,
  parameter int FREE_ID_MIN     = 1,
  parameter int FREE_ID_MAX     = 254
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         dplca_txop_table_upd,
  input  logic [511:0] txop_claim_table_unpacked,
  output logic         eval_busy,
  output logic         eval_done,
  output logic [8:0]   claimed_cnt,
  output logic [7:0]   highest_claimed_id,
  output logic         highest_claimed_valid,
  output logic [7:0]   dplca_max_id_calc,
  output logic [7:0]   free_id,
  output logic         free_id_valid
`ifdef DPLCA_EVAL_STATS_EN
  ,
  output logic [15:0]  eval_cnt,
  output logic [7:0]   overrun_cnt
`endif
);
  localparam logic [7:0] LAST_IDX = 8'(TBL_DEPTH - 1);

  state_t                   r_state, w_nxt;
  logic                     r_upd_q, r_pending;
  logic [7:0]               r_idx;
  logic [2*TBL_DEPTH-1:0]   r_tbl;
  logic                     w_edge;
  logic [1:0]               w_entry;
  logic [8:0]               w_cnt;
  logic [7:0]               w_hi, w_free, w_max;
  logic                     w_hv, w_fv;

  assign w_edge    = dplca_txop_table_upd && !r_upd_q;
  assign w_entry   = r_tbl[{r_idx, 1'b0} +: 2];
  assign w_max     = sat_max_id(w_hi, w_hv, 8'(MAX_ID_HEADROOM));
  assign eval_busy = (r_state == ST_SNAPSHOT) || (r_state == ST_SCAN) || (r_state == ST_CALC);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_edge) w_nxt = ST_SNAPSHOT;
      ST_SNAPSHOT: w_nxt = ST_SCAN;
      ST_SCAN:     if (r_idx == LAST_IDX) w_nxt = ST_CALC;
      ST_CALC:     w_nxt = ST_DONE;
      // An edge landing in DONE itself is folded in rather than lost.
      ST_DONE:     w_nxt = (r_pending || w_edge) ? ST_SNAPSHOT : ST_IDLE;
      default:     w_nxt = ST_IDLE;
    endcase
  end

  // Snapshot is unreset storage; it is only consumed after a SNAPSHOT cycle.
  always_ff @(posedge clk) begin
    if (r_state == ST_SNAPSHOT) r_tbl <= txop_claim_table_unpacked;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_upd_q               <= 1'b0;
      r_pending             <= 1'b0;
      r_idx                 <= '0;
      eval_done             <= 1'b0;
      claimed_cnt           <= '0;
      highest_claimed_id    <= '0;
      highest_claimed_valid <= 1'b0;
      dplca_max_id_calc     <= '0;
      free_id               <= 8'(FREE_ID_MIN);
      free_id_valid         <= 1'b0;
    end else begin
      r_upd_q   <= dplca_txop_table_upd;
      eval_done <= 1'b0;
      if (r_state == ST_SNAPSHOT) r_idx <= '0;
      if (r_state == ST_SCAN)     r_idx <= r_idx + 8'd1;
      if (r_state == ST_CALC) begin
        eval_done             <= 1'b1;
        claimed_cnt           <= w_cnt;
        highest_claimed_id    <= w_hi;
        highest_claimed_valid <= w_hv;
        dplca_max_id_calc     <= w_max;
        free_id               <= w_free;
        free_id_valid         <= w_fv;
      end
      if (r_state == ST_DONE)
        r_pending <= 1'b0;
      else if (r_state != ST_IDLE && w_edge)
        r_pending <= 1'b1;
    end
  end

`ifdef DPLCA_EVAL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      eval_cnt    <= '0;
      overrun_cnt <= '0;
    end else begin
      if (r_state == ST_CALC) eval_cnt <= eval_cnt + 16'd1;
      if (w_edge && r_pending && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

  dplca_claim_scan_acc #(
    .FREE_ID_MIN (FREE_ID_MIN),
    .FREE_ID_MAX (FREE_ID_MAX)
  ) u_acc (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clr     (r_state == ST_SNAPSHOT),
    .i_en      (r_state == ST_SCAN),
    .i_idx     (r_idx),
    .i_entry   (w_entry),
    .o_cnt     (w_cnt),
    .o_highest (w_hi),
    .o_hvalid  (w_hv),
    .o_free    (w_free),
    .o_fvalid  (w_fv)
  );
endmodule

// File: tb/tb_dplca_txop_table_eval.sv
// Scoreboard bench for dplca_txop_table_eval: expected results are queued at each upd edge
// and checked (values and completion cycle) whenever eval_done pulses.
module tb_dplca_txop_table_eval;
  import dplca_txop_table_eval_pkg::*;

  typedef struct {
    logic [8:0] cnt;
    logic [7:0] hi;
    logic       hv;
    logic [7:0] mx;
    logic [7:0] fr;
    logic       fv;
    int         cyc;
  } exp_t;

  logic         clk = 1'b0, reset = 1'b1, upd = 1'b0;
  logic [511:0] tbl;
  logic         eval_busy, eval_done, highest_claimed_valid, free_id_valid;
  logic [8:0]   claimed_cnt;
  logic [7:0]   highest_claimed_id, dplca_max_id_calc, free_id;
`ifdef DPLCA_EVAL_STATS_EN
  logic [15:0]  eval_cnt;
  logic [7:0]   overrun_cnt;
`endif

  dplca_txop_table_eval dut (
    .clk                       (clk),
    .reset                     (reset),
    .dplca_txop_table_upd      (upd),
    .txop_claim_table_unpacked (tbl),
    .eval_busy                 (eval_busy),
    .eval_done                 (eval_done),
    .claimed_cnt               (claimed_cnt),
    .highest_claimed_id        (highest_claimed_id),
    .highest_claimed_valid     (highest_claimed_valid),
    .dplca_max_id_calc         (dplca_max_id_calc),
    .free_id                   (free_id),
    .free_id_valid             (free_id_valid)
`ifdef DPLCA_EVAL_STATS_EN
    ,
    .eval_cnt                  (eval_cnt),
    .overrun_cnt               (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_chk = 0, n_pass = 0, exp_evals = 0;
  exp_t sb[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic exp_t model(input logic [511:0] t, input int c);
    exp_t e;
    int   m;
    e = '{cnt: 9'd0, hi: 8'd0, hv: 1'b0, mx: 8'd0, fr: 8'd1, fv: 1'b0, cyc: c};
    for (int i = 0; i < 256; i++) begin
      if (t[2*i +: 2] == CLAIMED) begin
        e.cnt = e.cnt + 9'd1;
        e.hi  = 8'(i);
        e.hv  = 1'b1;
      end else if (i >= 1 && i <= 254 && !e.fv) begin
        e.fr = 8'(i);
        e.fv = 1'b1;
      end
    end
    m    = int'(e.hi) + 2;
    e.mx = !e.hv ? 8'd1 : (m > 255 ? 8'd255 : 8'(m));
    return e;
  endfunction

  function automatic logic [511:0] claim(input logic [511:0] t, input int i);
    logic [511:0] r;
    r = t;
    r[2*i +: 2] = CLAIMED;
    return r;
  endfunction

  // Result monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset && eval_done) begin
      if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("claimed_cnt", claimed_cnt, e.cnt);
        chk("highest_valid", highest_claimed_valid, e.hv);
        if (e.hv) chk("highest_id", highest_claimed_id, e.hi);
        chk("max_id_calc", dplca_max_id_calc, e.mx);
        chk("free_valid", free_id_valid, e.fv);
        if (e.fv) chk("free_id", free_id, e.fr);
        chk("busy_in_done", eval_busy, 1'b0);
      end
    end
  end

  task automatic pulse_upd(input logic [511:0] t, input int done_at_offset, input bit push);
    @(posedge clk); #1;
    tbl = t;
    upd = 1'b1;
    if (push) begin
      sb.push_back(model(t, cyc + done_at_offset));
      exp_evals++;
    end
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({tag, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt"}, claimed_cnt, 9'd0);
    chk({tag, "_hi"}, highest_claimed_id, 8'd0);
    chk({tag, "_hv"}, highest_claimed_valid, 1'b0);
    chk({tag, "_max"}, dplca_max_id_calc, 8'd0);
    chk({tag, "_free"}, free_id, 8'd1);
    chk({tag, "_fv"}, free_id_valid, 1'b0);
    chk({tag, "_busy"}, eval_busy, 1'b0);
    chk({tag, "_done"}, eval_done, 1'b0);
  endtask

  initial begin
    logic [511:0] t, t2;
    tbl = {256{UNCLAIMED}};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("reset");

    // All unclaimed.
    pulse_upd({256{UNCLAIMED}}, 259, 1'b1);
    repeat (5) @(posedge clk);
    #1 chk("busy_scan", eval_busy, 1'b1);
    upd = 1'b0;
    wait_empty("empty");

    // IDs 0,1,3,7 claimed; other entries use non-01 codes.
    t = {256{2'b10}};
    t = claim(claim(claim(claim(t, 0), 1), 3), 7);
    pulse_upd(t, 259, 1'b1);
    @(posedge clk); #1 upd = 1'b0;
    wait_empty("sparse");

    // Boundaries: 0..253 claimed; 1..254 claimed; all claimed; random mix.
    t = {256{UNCLAIMED}};
    for (int i = 0; i < 254; i++) t = claim(t, i);
    pulse_upd(t, 259, 1'b1);
    @(posedge clk); #1 upd = 1'b0;
    wait_empty("hi253");
    t = {256{2'b10}};
    for (int i = 1; i < 255; i++) t = claim(t, i);
    pulse_upd(t, 259, 1'b1);
    @(posedge clk); #1 upd = 1'b0;
    wait_empty("hi254");
    for (int i = 0; i < 16; i++) t[32*i +: 32] = $urandom;
    pulse_upd(t, 259, 1'b1);
    @(posedge clk); #1 upd = 1'b0;
    wait_empty("random");
    pulse_upd({256{CLAIMED}}, 259, 1'b1);
    @(posedge clk); #1 upd = 1'b0;
    wait_empty("full");

    // Reset mid-scan: no result, outputs back to reset values.
    pulse_upd(t, 259, 1'b0);
    @(posedge clk); #1 upd = 1'b0;
    repeat (149) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("midreset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_evals = 0;
    repeat (300) @(posedge clk);
    #1 chk_reset_vals("noresult");
    t = {256{UNCLAIMED}};
    t = claim(claim(t, 1), 200);
    pulse_upd(t, 259, 1'b1);
    @(posedge clk); #1 upd = 1'b0;
    wait_empty("fresh");

    // Second edge mid-scan with table changed after snapshot; a third edge collapses.
    t = {256{UNCLAIMED}};
    t = claim(claim(t, 5), 9);
    pulse_upd(t, 259, 1'b1);
    @(posedge clk); #1 upd = 1'b0;
    repeat (98) @(posedge clk);
    t2 = {256{CLAIMED}};
    t2[2*40 +: 2] = UNCLAIMED;
    t2[2*255 +: 2] = 2'b11;
    #1 tbl = t2;
    pulse_upd(t2, 518 - 100, 1'b1);
    @(posedge clk); #1 upd = 1'b0;
    repeat (18) @(posedge clk);
    #1 upd = 1'b1;
    @(posedge clk); #1 upd = 1'b0;
    wait_empty("pending");

    // upd held high across a whole evaluation: exactly one result.
    pulse_upd({256{UNCLAIMED}}, 259, 1'b1);
    repeat (600) @(posedge clk);
    #1 upd = 1'b0;
    wait_empty("held");
    repeat (10) @(posedge clk);
    #1 chk("queue_empty", sb.size(), 0);

`ifdef DPLCA_EVAL_STATS_EN
    chk("eval_cnt", eval_cnt, exp_evals);
    chk("overrun_cnt", overrun_cnt, 8'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
